// File: rtl/toggle_cov_pkg.sv
// Shared definitions for the toggle-coverage monitor.
//   state_t      : sequencing states (warm-up, prime, active monitoring)
//   rise_idx()   : valid/map bit index of a rising edge on signal bit i
//   fall_idx()   : valid/map bit index of a falling edge on signal bit i
//   count_width(): width needed to hold 0..2*width distinct toggle points
package toggle_cov_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_PRIME  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    function automatic int rise_idx(input int i);
        return 2 * i;
    endfunction

    function automatic int fall_idx(input int i);
        return 2 * i + 1;
    endfunction

    function automatic int count_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Combinational population count of the newly covered toggle points.
//   bits  : input  N   one bit per toggle point seen for the first time
//   count : output CW  number of set bits in 'bits'
module toggle_popcount #(
    parameter int N  = 22,
    parameter int CW = 5
) (
    input  logic [N-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/toggle_detect.sv
// Toggle-coverage monitor: records which rise/fall points of a signal bus
// have been observed and emits one-cycle pulses for detected toggles.
//   clock       : input  1          rising-edge clock
//   reset       : input  1          asynchronous active-low reset
//   en          : input  1          detection enable
//   clear       : input  1          synchronous clear of map and count
//   sig         : input  WIDTH      monitored bus
//   valid       : output 2*WIDTH    toggle pulses (2i = rise, 2i+1 = fall)
//   cover_count : output CW         number of distinct toggle points seen
//   all_covered : output 1          every toggle point has been seen
module toggle_detect
    import toggle_cov_pkg::*;
#(
    parameter int WIDTH  = 11,
    parameter int WARMUP = 2,
    parameter int ONCE   = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 clear,
    input  logic [WIDTH-1:0]                     sig,
    output logic [2*WIDTH-1:0]                   valid,
    output logic [count_width(WIDTH)-1:0]        cover_count,
    output logic                                 all_covered
);

    localparam int     NP        = 2 * WIDTH;
    localparam int     CW        = count_width(WIDTH);
    localparam int     WCW       = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam state_t RST_STATE = (WARMUP > 0) ? ST_WARMUP : ST_PRIME;

    state_t             state_reg, state_next;
    logic [WCW-1:0]     warm_cnt_reg, warm_cnt_next;
    logic [WIDTH-1:0]   prev_reg;
    logic [NP-1:0]      map_reg;
    logic [NP-1:0]      valid_reg;
    logic [CW-1:0]      count_reg;
    logic               all_cov_reg;

    logic               detect_en;
    logic [NP-1:0]      det;
    logic [NP-1:0]      new_pts;
    logic [CW-1:0]      new_cnt;

    // Toggles coinciding with clear are dropped entirely, so clear gates
    // detection just like en does.
    assign detect_en = (state_reg == ST_ACTIVE) && en && !clear;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_det
        assign det[rise_idx(gi)] = detect_en & ~prev_reg[gi] &  sig[gi];
        assign det[fall_idx(gi)] = detect_en &  prev_reg[gi] & ~sig[gi];
    end

    // Points not yet in the map; only these move the count, which is
    // why the count can never exceed NP.
    assign new_pts = det & ~map_reg;

    toggle_popcount #(
        .N  (NP),
        .CW (CW)
    ) u_popcount (
        .bits  (new_pts),
        .count (new_cnt)
    );

    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        case (state_reg)
            ST_WARMUP: begin
                warm_cnt_next = warm_cnt_reg + 1'b1;
                if (int'(warm_cnt_reg) == WARMUP - 1) begin
                    state_next = ST_PRIME;
                end
            end
            ST_PRIME:  state_next = ST_ACTIVE;
            ST_ACTIVE: state_next = ST_ACTIVE;
            default:   state_next = RST_STATE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= RST_STATE;
            warm_cnt_reg <= '0;
            prev_reg     <= '0;
            map_reg      <= '0;
            valid_reg    <= '0;
            count_reg    <= '0;
            all_cov_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
            // prev keeps following sig even while disabled or clearing, so
            // edges that happen then are never reported afterwards.
            if (state_reg != ST_WARMUP) begin
                prev_reg <= sig;
            end
            if (clear) begin
                map_reg     <= '0;
                valid_reg   <= '0;
                count_reg   <= '0;
                all_cov_reg <= 1'b0;
            end else begin
                map_reg     <= map_reg | new_pts;
                valid_reg   <= (ONCE != 0) ? new_pts : det;
                count_reg   <= count_reg + new_cnt;
                all_cov_reg <= &(map_reg | new_pts);
            end
        end
    end

    assign valid       = valid_reg;
    assign cover_count = count_reg;
    assign all_covered = all_cov_reg;

endmodule

// File: tb/tb_toggle_detect.sv
module tb_toggle_detect;
    import toggle_cov_pkg::*;

    localparam int W  = 11;
    localparam int NP = 2 * W;
    localparam int CW = 5;

    logic          clock;
    logic          reset;
    logic          en;
    logic          clear;
    logic [W-1:0]  sig;
    logic [NP-1:0] valid1, valid0;
    logic [CW-1:0] cnt1, cnt0;
    logic          all1, all0;

    int n_total  = 0;
    int n_passed = 0;

    // Report-once instance
    toggle_detect #(.WIDTH(W), .WARMUP(2), .ONCE(1)) u_once (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .clear       (clear),
        .sig         (sig),
        .valid       (valid1),
        .cover_count (cnt1),
        .all_covered (all1)
    );

    // Report-every-occurrence instance, driven by the same stimulus
    toggle_detect #(.WIDTH(W), .WARMUP(2), .ONCE(0)) u_every (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .clear       (clear),
        .sig         (sig),
        .valid       (valid0),
        .cover_count (cnt0),
        .all_covered (all0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          en;
        logic          clr;
        logic [W-1:0]  sig;
        logic [NP-1:0] v1;
        logic [NP-1:0] v0;
        logic [CW-1:0] cnt;
        logic          all;
    } vec_t;

    typedef struct {
        logic [NP-1:0] v1;
        logic [NP-1:0] v0;
        logic [CW-1:0] cnt;
        logic          all;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[21];
    int   step_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got %h, required %h", name, act, req);
        else
            n_passed++;
    endtask

    // Drive one cycle of stimulus, queue its expected result, and compare
    // the DUT outputs just after the clock edge that consumes it.
    task automatic step(input logic e, input logic c, input logic [W-1:0] s,
                        input logic [NP-1:0] xv1, input logic [NP-1:0] xv0,
                        input logic [CW-1:0] xc, input logic xa);
        exp_t x;
        en    = e;
        clear = c;
        sig   = s;
        x.v1 = xv1; x.v0 = xv0; x.cnt = xc; x.all = xa;
        exp_q.push_back(x);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: got empty queue, required one entry");
            n_total++;
        end else begin
            x = exp_q.pop_front();
            chk("valid_once",  32'(valid1), 32'(x.v1));
            chk("valid_every", 32'(valid0), 32'(x.v0));
            chk("count_once",  32'(cnt1),   32'(x.cnt));
            chk("count_every", 32'(cnt0),   32'(x.cnt));
            chk("all_covered", 32'(all1),   32'(x.all));
            chk("all_cov_ev",  32'(all0),   32'(x.all));
        end
        $display("step %0d en=%b clr=%b sig=%h valid1=%h valid0=%h count=%0d all=%b",
                 step_no, e, c, s, valid1, valid0, cnt1, all1);
        step_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        //        en    clr   sig      v1 (ONCE=1) v0 (ONCE=0) cnt    all
        tbl[0]  = '{1'b1, 1'b0, 11'h000, 22'h000000, 22'h000000, 5'd0,  1'b0}; // warmup
        tbl[1]  = '{1'b1, 1'b0, 11'h000, 22'h000000, 22'h000000, 5'd0,  1'b0}; // warmup
        tbl[2]  = '{1'b1, 1'b0, 11'h000, 22'h000000, 22'h000000, 5'd0,  1'b0}; // prime
        tbl[3]  = '{1'b1, 1'b0, 11'h001, 22'h000001, 22'h000001, 5'd1,  1'b0}; // first rise
        tbl[4]  = '{1'b1, 1'b0, 11'h001, 22'h000000, 22'h000000, 5'd1,  1'b0};
        tbl[5]  = '{1'b1, 1'b1, 11'h001, 22'h000000, 22'h000000, 5'd0,  1'b0}; // clear
        tbl[6]  = '{1'b1, 1'b0, 11'h009, 22'h000040, 22'h000040, 5'd1,  1'b0}; // sig[3] rise
        tbl[7]  = '{1'b1, 1'b0, 11'h001, 22'h000080, 22'h000080, 5'd2,  1'b0}; // sig[3] fall
        tbl[8]  = '{1'b1, 1'b0, 11'h009, 22'h000000, 22'h000040, 5'd2,  1'b0}; // repeat rise
        tbl[9]  = '{1'b1, 1'b0, 11'h009, 22'h000000, 22'h000000, 5'd2,  1'b0};
        tbl[10] = '{1'b0, 1'b0, 11'h029, 22'h000000, 22'h000000, 5'd2,  1'b0}; // sig[5] rise, en=0
        tbl[11] = '{1'b1, 1'b0, 11'h029, 22'h000000, 22'h000000, 5'd2,  1'b0}; // not reported later
        tbl[12] = '{1'b1, 1'b1, 11'h02D, 22'h000000, 22'h000000, 5'd0,  1'b0}; // clear + sig[2] rise
        tbl[13] = '{1'b1, 1'b0, 11'h02D, 22'h000000, 22'h000000, 5'd0,  1'b0};
        tbl[14] = '{1'b1, 1'b1, 11'h000, 22'h000000, 22'h000000, 5'd0,  1'b0}; // clear + falls
        tbl[15] = '{1'b1, 1'b0, 11'h7FF, 22'h155555, 22'h155555, 5'd11, 1'b0}; // all rise
        tbl[16] = '{1'b1, 1'b0, 11'h000, 22'h2AAAAA, 22'h2AAAAA, 5'd22, 1'b1}; // all fall
        tbl[17] = '{1'b1, 1'b0, 11'h7FF, 22'h000000, 22'h155555, 5'd22, 1'b1}; // saturated
        tbl[18] = '{1'b1, 1'b1, 11'h7FF, 22'h000000, 22'h000000, 5'd0,  1'b0}; // clear
        tbl[19] = '{1'b1, 1'b0, 11'h7FF, 22'h000000, 22'h000000, 5'd0,  1'b0};
        tbl[20] = '{1'b1, 1'b0, 11'h780, 22'h002AAA, 22'h002AAA, 5'd7,  1'b0}; // 7 falls

        reset = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        sig   = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid",  32'(valid1), 32'h0);
        chk("reset_count",  32'(cnt1),   32'h0);
        chk("reset_allcov", 32'(all1),   32'h0);

        reset = 1'b1;
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].sig, tbl[i].v1, tbl[i].v0,
                 tbl[i].cnt, tbl[i].all);
        end

        // Asynchronous reset mid-ACTIVE with cover_count=7: outputs clear
        // before any clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid",  32'(valid1), 32'h0);
        chk("async_count",  32'(cnt1),   32'h0);
        chk("async_allcov", 32'(all1),   32'h0);
        chk("async_count0", 32'(cnt0),   32'h0);
        reset = 1'b1;

        // Toggling throughout warmup and prime must not produce pulses.
        step(1'b1, 1'b0, 11'h7FF, 22'h0, 22'h0, 5'd0, 1'b0); // warmup 1
        step(1'b1, 1'b0, 11'h000, 22'h0, 22'h0, 5'd0, 1'b0); // warmup 2
        step(1'b1, 1'b0, 11'h7FF, 22'h0, 22'h0, 5'd0, 1'b0); // prime
        step(1'b1, 1'b0, 11'h7FE, 22'h000002, 22'h000002, 5'd1, 1'b0); // sig[0] fall
        step(1'b1, 1'b0, 11'h7FE, 22'h0, 22'h0, 5'd1, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
